// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Drives the ALU function and operands from the registered decode fields.
module id_ex_operand_stage #(
    parameter int         DW     = 32,
    parameter int         RW     = 5,
    parameter logic [5:0] NOP_FN = 6'b100000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [5:0]    id_func,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_is_shift,
    input  logic [4:0]    id_shamt,
    input  logic [RW-1:0] id_dest,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          flush_in,
    input  logic          stall_in,
    input  logic [RW-1:0] exmem_dest,
    input  logic          exmem_reg_write,
    input  logic [DW-1:0] exmem_data,
    input  logic [RW-1:0] memwb_dest,
    input  logic          memwb_reg_write,
    input  logic [DW-1:0] memwb_data,
    output logic          stall_out,
    output logic [5:0]    alu_func,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_valid,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
);

    typedef struct packed {
        logic          valid;
        logic [5:0]    func;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic          is_shift;
        logic [4:0]    shamt;
        logic [RW-1:0] dest;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    ex_t bubble;
    ex_t decoded;

    logic          load_use;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_val,
        input logic          em_we,
        input logic [RW-1:0] em_dest,
        input logic [DW-1:0] em_data,
        input logic          mw_we,
        input logic [RW-1:0] mw_dest,
        input logic [DW-1:0] mw_data
    );
        if (idx == '0) begin
            fwd_sel = rf_val;
        end else if (em_we && (em_dest == idx)) begin
            fwd_sel = em_data;
        end else if (mw_we && (mw_dest == idx)) begin
            fwd_sel = mw_data;
        end else begin
            fwd_sel = rf_val;
        end
    endfunction

    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid &&
                   ((id_uses_rs && (id_rs == ex_q.dest)) ||
                    (id_uses_rt && (id_rt == ex_q.dest)));
    end

    assign stall_out = stall_in | (load_use & ~flush_in);

    always_comb begin
        bubble      = '0;
        bubble.func = NOP_FN;

        decoded           = '0;
        decoded.valid     = 1'b1;
        decoded.func      = id_func;
        decoded.rs        = id_rs;
        decoded.rt        = id_rt;
        decoded.rs_data   = id_rs_data;
        decoded.rt_data   = id_rt_data;
        decoded.imm       = id_imm;
        decoded.use_imm   = id_use_imm;
        decoded.is_shift  = id_is_shift;
        decoded.shamt     = id_shamt;
        decoded.dest      = id_dest;
        decoded.reg_write = id_reg_write;
        decoded.mem_read  = id_mem_read;
        decoded.mem_write = id_mem_write;

        // Downstream stall outranks flush: the flush source keeps asserting until EX moves.
        ex_d = ex_q;
        if (stall_in) begin
            ex_d = ex_q;
        end else if (flush_in || load_use || !id_valid) begin
            ex_d = bubble;
        end else begin
            ex_d = decoded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX stage: forwarding and operand select.
    assign fwd_rs = fwd_sel(ex_q.rs, ex_q.rs_data, exmem_reg_write, exmem_dest, exmem_data,
                            memwb_reg_write, memwb_dest, memwb_data);
    assign fwd_rt = fwd_sel(ex_q.rt, ex_q.rt_data, exmem_reg_write, exmem_dest, exmem_data,
                            memwb_reg_write, memwb_dest, memwb_data);

    always_comb begin
        if (ex_q.is_shift) begin
            alu_a = fwd_rt;
            alu_b = {{(DW-5){1'b0}}, ex_q.shamt};
        end else begin
            alu_a = fwd_rs;
            alu_b = ex_q.use_imm ? ex_q.imm : fwd_rt;
        end
    end

    assign ex_store_data = fwd_rt;
    assign alu_func      = ex_q.valid ? ex_q.func : NOP_FN;
    assign ex_valid      = ex_q.valid;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX contents are queued when
// decode is driven and compared once the clock edge has loaded the stage.
module tb_id_ex_operand_stage;

    localparam int         DW  = 32;
    localparam int         RW  = 5;
    localparam logic [5:0] NOP = 6'b100000;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [5:0]    id_func;
    logic [RW-1:0] id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_use_imm, id_is_shift;
    logic [4:0]    id_shamt;
    logic [RW-1:0] id_dest;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          flush_in, stall_in;
    logic [RW-1:0] exmem_dest, memwb_dest;
    logic          exmem_reg_write, memwb_reg_write;
    logic [DW-1:0] exmem_data, memwb_data;
    logic          stall_out;
    logic [5:0]    alu_func;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic          ex_valid;
    logic [RW-1:0] ex_dest;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_operand_stage #(.DW(DW), .RW(RW), .NOP_FN(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_func(id_func),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_is_shift(id_is_shift), .id_shamt(id_shamt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush_in(flush_in), .stall_in(stall_in),
        .exmem_dest(exmem_dest), .exmem_reg_write(exmem_reg_write), .exmem_data(exmem_data),
        .memwb_dest(memwb_dest), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .stall_out(stall_out), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [5:0]  func;
        logic [4:0]  rs, rt;
        logic [31:0] rsd, rtd, imm;
        logic        use_imm, is_shift;
        logic [4:0]  shamt, dest;
        logic        rw, mr, mw;
    } ex_t;

    ex_t m;
    ex_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (exmem_reg_write && exmem_dest == idx) return exmem_data;
        if (memwb_reg_write && memwb_dest == idx) return memwb_data;
        return rf;
    endfunction

    task automatic clear_id();
        id_valid = 0; id_func = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0; id_is_shift = 0;
        id_shamt = 0; id_dest = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush_in = 0; stall_in = 0;
    endtask

    task automatic clear_fwd();
        exmem_dest = 0; exmem_reg_write = 0; exmem_data = 0;
        memwb_dest = 0; memwb_reg_write = 0; memwb_data = 0;
    endtask

    task automatic set_instr(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] dest, input logic urs, input logic urt,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                             input logic uimm, input logic shift, input logic [4:0] sh,
                             input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_func = fn; id_rs = rs; id_rt = rt; id_dest = dest;
        id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_use_imm = uimm; id_is_shift = shift; id_shamt = sh;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    // One clock: check combinational outputs against the model, queue the next EX
    // contents, then after the edge pop and compare the registered fields.
    task automatic step(input string tag);
        logic lu;
        ex_t  nx;
        #1;
        lu = m.valid && m.mr && (m.dest != 0) && id_valid &&
             ((id_uses_rs && id_rs == m.dest) || (id_uses_rt && id_rt == m.dest));
        check_val({tag, ":stall_out"}, {31'b0, stall_out}, {31'b0, stall_in | (lu & ~flush_in)});
        if (m.valid) begin
            check_val({tag, ":alu_a"}, alu_a, m.is_shift ? mfwd(m.rt, m.rtd) : mfwd(m.rs, m.rsd));
            check_val({tag, ":alu_b"}, alu_b, m.is_shift ? {27'b0, m.shamt} :
                                              (m.use_imm ? m.imm : mfwd(m.rt, m.rtd)));
            check_val({tag, ":store"}, ex_store_data, mfwd(m.rt, m.rtd));
        end
        if (stall_in) begin
            nx = m;
        end else if (flush_in || lu || !id_valid) begin
            nx = '0;
        end else begin
            nx = '{valid: 1'b1, func: id_func, rs: id_rs, rt: id_rt, rsd: id_rs_data,
                   rtd: id_rt_data, imm: id_imm, use_imm: id_use_imm, is_shift: id_is_shift,
                   shamt: id_shamt, dest: id_dest, rw: id_reg_write, mr: id_mem_read,
                   mw: id_mem_write};
        end
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            m = exp_q.pop_front();
            check_val({tag, ":ex_valid"}, {31'b0, ex_valid}, {31'b0, m.valid});
            check_val({tag, ":alu_func"}, {26'b0, alu_func}, {26'b0, m.valid ? m.func : NOP});
            check_val({tag, ":ctl"}, {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, 2'b0},
                      {27'b0, m.rw, m.mr, m.mw, 2'b0});
            if (m.valid) check_val({tag, ":ex_dest"}, {27'b0, ex_dest}, {27'b0, m.dest});
        end
    endtask

    initial begin
        rst_n = 0;
        clear_id();
        clear_fwd();
        m = '0;
        #3;
        check_val("rst:ex_valid", {31'b0, ex_valid}, 32'd0);
        check_val("rst:alu_func", {26'b0, alu_func}, {26'b0, NOP});
        check_val("rst:stall_out", {31'b0, stall_out}, 32'd0);
        check_val("rst:ex_ctl", {27'b0, ex_dest}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        step("idle");

        // T1: EX/MEM beats MEM/WB, then MEM/WB alone
        set_instr(6'b100000, 1, 2, 3, 1, 1, 100, 200, 0, 0, 0, 0, 1, 0, 0);
        step("t1_issue");
        clear_id();
        exmem_dest = 1; exmem_reg_write = 1; exmem_data = 5;
        memwb_dest = 1; memwb_reg_write = 1; memwb_data = 9;
        stall_in = 1;
        #1 check_val("t1_a_exmem", alu_a, 32'd5);
        step("t1_exmem");
        stall_in = 0; exmem_reg_write = 0;
        #1 check_val("t1_a_memwb", alu_a, 32'd9);
        step("t1_memwb");

        // T2: register 0 never forwarded
        clear_fwd();
        set_instr(6'b100000, 0, 2, 7, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        step("t2_issue");
        clear_id();
        exmem_dest = 0; exmem_reg_write = 1; exmem_data = 32'hDEAD;
        #1 check_val("t2_a_r0", alu_a, 32'd0);
        step("t2_r0");

        // T3: load-use stall for one cycle, then forward load data from MEM/WB
        clear_fwd();
        set_instr(6'b100000, 1, 0, 4, 1, 0, 32'h100, 0, 4, 1, 0, 0, 1, 1, 0);
        step("t3_lw");
        set_instr(6'b100000, 4, 1, 5, 1, 1, 0, 32'h11, 0, 0, 0, 0, 1, 0, 0);
        #1 check_val("t3_stall", {31'b0, stall_out}, 32'd1);
        step("t3_hazard");
        check_val("t3_bubble_func", {26'b0, alu_func}, 32'h20);
        step("t3_reissue");
        clear_id();
        memwb_dest = 4; memwb_reg_write = 1; memwb_data = 32'h1234;
        #1 check_val("t3_a_load", alu_a, 32'h1234);
        step("t3_use");

        // T4: flush overrides load-use; downstream stall holds EX
        clear_fwd();
        set_instr(6'b100000, 1, 0, 4, 1, 0, 32'h100, 0, 4, 1, 0, 0, 1, 1, 0);
        step("t4_lw");
        set_instr(6'b100000, 4, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        flush_in = 1;
        step("t4_flush");
        flush_in = 0;
        set_instr(6'b100000, 1, 0, 4, 1, 0, 32'h100, 0, 4, 1, 0, 0, 1, 1, 0);
        step("t4_lw2");
        set_instr(6'b100000, 4, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        stall_in = 1;
        for (int i = 0; i < 3; i++) step("t4_hold");
        stall_in = 0;
        step("t4_release");
        step("t4_go");

        // T5: shift takes A from rt and B from shamt
        clear_fwd();
        set_instr(6'b000000, 0, 5, 6, 0, 1, 0, 1, 0, 0, 1, 31, 1, 0, 0);
        step("t5_issue");
        clear_id();
        #1 check_val("t5_a", alu_a, 32'h1);
        check_val("t5_b", alu_b, 32'h1F);
        check_val("t5_func", {26'b0, alu_func}, 32'h0);
        step("t5_sll");

        // Store data follows forwarded rt
        set_instr(6'b100000, 1, 6, 0, 1, 1, 32'h40, 32'h77, 8, 1, 0, 0, 0, 0, 1);
        step("sw_issue");
        clear_id();
        exmem_dest = 6; exmem_reg_write = 1; exmem_data = 32'hABCD;
        #1 check_val("sw_store", ex_store_data, 32'hABCD);
        step("sw_fwd");

        for (int i = 0; i < 40; i++) begin
            set_instr(6'($urandom), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                      5'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), $urandom,
                      $urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            id_valid        = ($urandom_range(0, 5) != 0);
            flush_in        = ($urandom_range(0, 7) == 0);
            stall_in        = ($urandom_range(0, 7) == 0);
            exmem_dest      = 5'($urandom_range(0, 5));
            exmem_reg_write = 1'($urandom);
            exmem_data      = $urandom;
            memwb_dest      = 5'($urandom_range(0, 5));
            memwb_reg_write = 1'($urandom);
            memwb_data      = $urandom;
            step("rand");
        end

        // T6: asynchronous reset clears a valid EX stage without a clock edge
        clear_id();
        clear_fwd();
        set_instr(6'b100010, 2, 3, 9, 1, 1, 7, 8, 0, 0, 0, 0, 1, 0, 0);
        step("t6_load");
        #2 rst_n = 0;
        #1 check_val("t6_valid", {31'b0, ex_valid}, 32'd0);
        check_val("t6_func", {26'b0, alu_func}, {26'b0, NOP});
        check_val("t6_rw", {31'b0, ex_reg_write}, 32'd0);
        m = '0;
        #2 rst_n = 1;
        step("t6_after");
        clear_id();
        step("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
